// File: rtl/dtg_1024x768.sv
// dtg_1024x768: 1024x768 @ 60 Hz VGA display timing generator on the 65 MHz pixel clock.
// Optional feature macro DTG_FRAME_TICK_EN builds the frame_tick decode at (column 0, row V_ACTIVE).
module dtg_1024x768 #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [11:0] pixel_column,
  output logic [11:0] pixel_row,
  output logic        horiz_sync,
  output logic        vert_sync,
  output logic        video_on,
  output logic        frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS    = 12'(H_ACTIVE);
  localparam logic [11:0] V_VIS    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [11:0] columnNext;
  logic [11:0] rowNext;
  logic        lineEnd;
  logic        hSyncNext;
  logic        vSyncNext;
  logic        videoOnNext;

  // Next raster position; >= keeps the counters bounded even from an illegal value.
  always_comb begin
    lineEnd    = (pixel_column >= H_LAST);
    columnNext = lineEnd ? 12'd0 : pixel_column + 12'd1;
    rowNext    = pixel_row;
    if (lineEnd) begin
      rowNext = (pixel_row >= V_LAST) ? 12'd0 : pixel_row + 12'd1;
    end
  end

  // Flags decode the next position so they register alongside the counters with no skew.
  always_comb begin
    hSyncNext   = ((columnNext >= HS_FIRST) && (columnNext <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vSyncNext   = ((rowNext >= VS_FIRST) && (rowNext <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    videoOnNext = (columnNext < H_VIS) && (rowNext < V_VIS);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pixel_column <= H_LAST;
      pixel_row    <= V_LAST;
      horiz_sync   <= ~SYNC_POL;
      vert_sync    <= ~SYNC_POL;
      video_on     <= 1'b0;
    end else begin
      pixel_column <= columnNext;
      pixel_row    <= rowNext;
      horiz_sync   <= hSyncNext;
      vert_sync    <= vSyncNext;
      video_on     <= videoOnNext;
    end
  end

`ifdef DTG_FRAME_TICK_EN
  logic frameTickNext;

  assign frameTickNext = (columnNext == 12'd0) && (rowNext == V_VIS);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frameTickNext;
    end
  end
`else
  assign frame_tick = 1'b0;
`endif

endmodule
